// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the 8x8 systolic array: weight load, credit-gated activation
// streaming and result collection into a small ready/valid drained FIFO.
module systolic_array_ctrl #(
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cfg_float,
    input  logic [7:0]  cfg_num_vec,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_spurious,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [63:0] w_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [63:0] a_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [63:0] r_data,
    output logic [7:0]  arr_load,
    output logic [63:0] arr_input_value,
    output logic        arr_input_valid,
    output logic        arr_float,
    input  logic        arr_output_valid,
    input  logic [63:0] arr_output_value
);
    localparam int unsigned AW = $clog2(RES_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(RES_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RES_DEPTH);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t        state;
    logic [2:0]    row;
    logic [7:0]    vec;
    logic [7:0]    num_vec;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [TW-1:0] timer;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [63:0]   mem [RES_DEPTH];

    logic          w_beat, a_beat, res_push, pop, push, tick, expire;
    logic [CW:0]   committed;

    // Credit uses registered count and outstanding, so a pop frees a slot next cycle.
    always_comb begin
        committed = {1'b0, fifo_count} + {1'b0, outstanding};
        busy      = (state != IDLE);
        w_ready   = (state == LOAD);
        a_ready   = (state == STREAM) && (committed < DEPTH_SUM);
        r_valid   = (fifo_count != '0);
        r_data    = mem[rd_ptr];
        w_beat    = w_valid && w_ready;
        a_beat    = a_valid && a_ready;
        res_push  = arr_output_valid && (outstanding != '0);
        pop       = r_valid && r_ready;
        push      = res_push && ((fifo_count != DEPTH_CNT) || pop);
        tick      = (outstanding != '0) && !arr_output_valid;
        expire    = tick && (timer == TIMER_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            row             <= '0;
            vec             <= '0;
            num_vec         <= '0;
            outstanding     <= '0;
            fifo_count      <= '0;
            timer           <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            done            <= 1'b0;
            err_timeout     <= 1'b0;
            err_spurious    <= 1'b0;
            arr_load        <= '0;
            arr_input_value <= '0;
            arr_input_valid <= 1'b0;
            arr_float       <= 1'b0;
            for (int unsigned i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
        end else begin
            done            <= 1'b0;
            arr_load        <= '0;
            arr_input_valid <= 1'b0;

            case (state)
                IDLE: if (start) begin
                    state        <= LOAD;
                    arr_float    <= cfg_float;
                    num_vec      <= cfg_num_vec;
                    row          <= '0;
                    vec          <= '0;
                    err_timeout  <= 1'b0;
                    err_spurious <= 1'b0;
                end
                LOAD: if (w_beat) begin
                    arr_load        <= 8'd1 << row;
                    arr_input_value <= w_data;
                    row             <= row + 3'd1;
                    if (row == 3'd7) state <= (num_vec != '0) ? STREAM : DRAIN;
                end
                STREAM: if (a_beat) begin
                    arr_input_valid <= 1'b1;
                    arr_input_value <= a_data;
                    vec             <= vec + 8'd1;
                    if (vec == num_vec - 8'd1) state <= DRAIN;
                end
                DRAIN: if (outstanding == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Set after the start-clear so a spurious strobe on the start cycle is kept.
            if (arr_output_valid && (outstanding == '0)) err_spurious <= 1'b1;

            if (arr_output_valid) timer <= '0;
            else if (tick)        timer <= timer + TW'(1);

            outstanding <= outstanding + CW'(a_beat) - CW'(res_push);

            if (expire) begin
                err_timeout <= 1'b1;
                outstanding <= '0;
                timer       <= '0;
                state       <= IDLE;
                done        <= 1'b1;
            end

            if (push) begin
                mem[wr_ptr] <= arr_output_value;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a behavioural 8-cycle array model.
module tb_systolic_array_ctrl;
    localparam int unsigned RES_DEPTH = 4;
    localparam int unsigned TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_float = 1'b0;
    logic [7:0]  cfg_num_vec = '0;
    logic        busy, done, err_timeout, err_spurious;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [63:0] w_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [63:0] a_data = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [63:0] r_data;
    logic [7:0]  arr_load;
    logic [63:0] arr_input_value;
    logic        arr_input_valid;
    logic        arr_float;
    logic        arr_output_valid;
    logic [63:0] arr_output_value;

    always #5 clk = ~clk;

    systolic_array_ctrl #(.RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_float(cfg_float), .cfg_num_vec(cfg_num_vec),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_spurious(err_spurious),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .arr_load(arr_load), .arr_input_value(arr_input_value), .arr_input_valid(arr_input_valid),
        .arr_float(arr_float), .arr_output_valid(arr_output_valid), .arr_output_value(arr_output_value)
    );

    // Array model: out byte j = sum_i a byte i * w[i] byte j (mod 256), latency 8.
    logic [63:0] wmem [8];
    logic [63:0] pd [8];
    logic [7:0]  pv = '0;
    logic        model_en = 1'b1;
    logic        spur = 1'b0;

    function automatic logic [63:0] mac(input logic [63:0] a);
        logic [63:0] r;
        logic [7:0]  acc;
        logic [15:0] prod;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int i = 0; i < 8; i++) begin
                prod = a[8*i +: 8] * wmem[i][8*j +: 8];
                acc  = acc + prod[7:0];
            end
            r[8*j +: 8] = acc;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (arr_load[i]) wmem[i] <= arr_input_value;
        pv    <= {pv[6:0], arr_input_valid & model_en};
        pd[0] <= mac(arr_input_value);
        for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
    end

    assign arr_output_valid = pv[7] | spur;
    assign arr_output_value = spur ? 64'hDEAD_BEEF_0000_0001 : pd[7];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    int          issued, target, nres, iv_cnt, done_cnt, done_at, last_ov, issue_at;
    logic [63:0] res [16];
    logic [63:0] act [16];

    task automatic reset_stats(input int tgt);
        issued = 0; target = tgt; nres = 0; iv_cnt = 0;
        done_cnt = 0; done_at = -1; last_ov = -1; issue_at = -1;
    endtask

    // One cycle: sample outputs at the falling edge, drive the next beat, advance.
    task automatic step();
        if (arr_input_valid) iv_cnt++;
        if (arr_output_valid) last_ov = cyc;
        if (done) begin done_cnt++; done_at = cyc; end
        if (r_valid && r_ready && nres < 16) begin res[nres] = r_data; nres++; end
        a_valid = (issued < target);
        a_data  = act[issued % 16];
        if (a_valid && a_ready) begin issue_at = cyc; issued++; end
        @(negedge clk); cyc++;
    endtask

    task automatic run_load(input logic flt, input logic [7:0] nv, input bit ident, input int nbeats);
        cfg_float = flt; cfg_num_vec = nv; start = 1'b1;
        @(negedge clk); cyc++;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("w_ready_in_load", w_ready, 1);
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1;
            w_data  = ident ? (64'h1 << (8*i)) : 64'h0101_0101_0101_0101;
            @(negedge clk); cyc++;
            check("arr_load", arr_load, 64'h1 << i);
            check("arr_w_value", arr_input_value, w_data);
        end
        w_valid = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int b;
        b = budget;
        while (!(nres == target && !busy && done_cnt > 0) && b > 0) begin
            step();
            b--;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_flags", {busy, done, err_timeout, err_spurious, w_ready, a_ready, r_valid,
                              arr_input_valid, arr_float}, 0);
        check("reset_arr_load", arr_load, 0);
        check("reset_arr_value", arr_input_value, 0);
        rst = 1'b0;
        @(negedge clk); cyc++;

        // Reset in the middle of a weight load
        run_load(1'b1, 8'd2, 1'b0, 3);
        check("float_latched", arr_float, 1);
        rst = 1'b1;
        #1;
        check("midreset_flags", {busy, done, err_timeout, err_spurious, w_ready, a_ready, r_valid,
                                 arr_input_valid, arr_float}, 0);
        check("midreset_arr_load", arr_load, 0);
        check("midreset_arr_value", arr_input_value, 0);
        @(negedge clk); cyc++;
        rst = 1'b0;
        @(negedge clk); cyc++;

        // Nominal int8 job: all-ones weights and activations give 8 per lane
        run_load(1'b0, 8'd2, 1'b0, 8);
        check("float_int8", arr_float, 0);
        reset_stats(2);
        act[0] = 64'h0101_0101_0101_0101;
        act[1] = 64'h0101_0101_0101_0101;
        r_ready = 1'b1;
        run_to_done(200);
        check("nom_issues", iv_cnt, 2);
        check("nom_results", nres, 2);
        check("nom_res0", res[0], 64'h0808_0808_0808_0808);
        check("nom_res1", res[1], 64'h0808_0808_0808_0808);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_done_lag", done_at - last_ov, 2);

        // Credit backpressure: identity weights echo each activation
        run_load(1'b0, 8'd10, 1'b1, 8);
        reset_stats(10);
        for (int k = 0; k < 16; k++) act[k] = 64'h0101_0101_0101_0101 * (64'h10 + 64'(k));
        r_ready = 1'b0;
        start = 1'b1; cfg_float = 1'b1;
        step();
        start = 1'b0; cfg_float = 1'b0;
        repeat (39) step();
        check("bp_issues", iv_cnt, 4);
        check("bp_issued", issued, 4);
        check("bp_a_ready", a_ready, 0);
        check("bp_r_valid", r_valid, 1);
        check("bp_start_ignored", arr_float, 0);
        r_ready = 1'b1;
        #1;
        check("credit_same_cycle", a_ready, 0);
        step();
        check("credit_after_pop", a_ready, 1);
        run_to_done(400);
        check("bp_issues_total", iv_cnt, 10);
        check("bp_results", nres, 10);
        for (int k = 0; k < 10; k++) check($sformatf("bp_res%0d", k), res[k], act[k]);
        check("bp_done_cnt", done_cnt, 1);
        check("bp_idle", busy, 0);

        // Timeout: array never answers
        model_en = 1'b0;
        run_load(1'b1, 8'd1, 1'b0, 8);
        reset_stats(1);
        begin
            int b;
            b = 300;
            while (!err_timeout && b > 0) begin step(); b--; end
        end
        check("to_latency", cyc - issue_at, TIMEOUT + 1);
        check("to_flag", err_timeout, 1);
        check("to_done", done, 1);
        check("to_idle", busy, 0);
        step();
        check("to_sticky", err_timeout, 1);
        check("to_done_pulse", done, 0);
        model_en = 1'b1;

        // Spurious result while idle
        spur = 1'b1;
        @(negedge clk); cyc++;
        spur = 1'b0;
        check("spur_flag", err_spurious, 1);
        check("spur_fifo_empty", r_valid, 0);
        @(negedge clk); cyc++;
        check("spur_sticky", err_spurious, 1);

        // Next accepted start clears both flags; zero vectors skip streaming
        run_load(1'b0, 8'd0, 1'b0, 8);
        check("clr_spurious", err_spurious, 0);
        check("clr_timeout", err_timeout, 0);
        reset_stats(0);
        run_to_done(50);
        check("nv0_done", done_cnt, 1);
        check("nv0_no_issue", iv_cnt, 0);
        check("nv0_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
